sram_rr_arbiter: RTL
====================

Name: sram_rr_arbiter

Overview:
- Parametrised successor to the fixed 2W/2R SRAM arbiter.
- Round-robin arbitration over NUM_W write channels and NUM_R read channels onto one SRAM command port, with a registered command stage.
- A tag FIFO records the channel ID of each issued read, so returned data is steered to its own channel rather than inferred from a fixed delay chain.
- Sits in the sram_clock domain, after the clock-crossing FIFOs and before the SRAM controller.

Parameters:
- NUM_W, 2, number of write channels (1..8)
- NUM_R, 2, number of read channels (1..8)
- ADDR_W, 18, SRAM word address width
- DATA_W, 32, data width
- MASK_W, 4, write byte mask width (DATA_W/8)
- TAG_DEPTH, 8, maximum reads outstanding (power of 2, >=2)

Ports:
- sram_clock  in  1  sole clock
- reset  in  1  synchronous active-high reset
- w_valid  in  NUM_W  write request valid, per channel
- w_ready  out  NUM_W  write request accepted this cycle
- w_addr  in  NUM_W*ADDR_W  write addresses, channel i at [i*ADDR_W +: ADDR_W]
- w_data  in  NUM_W*DATA_W  write data
- w_mask  in  NUM_W*MASK_W  write masks
- r_valid  in  NUM_R  read request valid
- r_ready  out  NUM_R  read request accepted this cycle
- r_addr  in  NUM_R*ADDR_W  read addresses
- r_dout_full  in  NUM_R  downstream return FIFO prog_full; blocks that channel
- r_dout_valid  out  NUM_R  one-hot write enable into the return FIFO
- r_dout  out  DATA_W  returned read data, shared by all channels
- sram_addr_valid  out  1  command valid
- sram_ready  in  1  SRAM accepts the command
- sram_addr  out  ADDR_W  command address
- sram_data_in  out  DATA_W  write data
- sram_write_mask  out  MASK_W  write mask; 0 means read
- sram_data_out  in  DATA_W  read data from SRAM
- sram_data_out_valid  in  1  read data valid
- outstanding  out  $clog2(TAG_DEPTH+1)  reads granted but not yet returned
- tag_underflow  out  1  sticky error flag

Behaviour:
- Requesters are indexed 0..NUM_W-1 for writes, then NUM_W..NUM_W+NUM_R-1 for reads.
- Eligibility:
  - Write i is eligible when w_valid[i].
  - Read j is eligible when r_valid[j], ~r_dout_full[j] and the tag FIFO is not full.
- Command register (cmd_reg): one entry holding {valid, addr, data, mask, is_read}.
  - It can load when it is empty, or when sram_addr_valid && sram_ready in the same cycle (pass-through, no bubble).
- Arbitration: when cmd_reg can load and at least one requester is eligible, grant the first eligible index after last_grant, wrapping modulo N.
  - On grant, pulse that requester's ready for 1 cycle, load cmd_reg, and set last_grant to that index.
  - ready is asserted only on a granted cycle; a channel must hold valid and its payload until it sees ready.
- Latency: request accepted in cycle N → sram_addr_valid in cycle N+1.
- SRAM command fields:
  - sram_addr_valid = cmd_reg.valid.
  - Read commands drive sram_write_mask=0 and sram_data_in=0.
  - A write with mask 0 is forwarded unchanged.
  - Commands hold stable while sram_ready=0.
- Tag FIFO (depth TAG_DEPTH, width $clog2(NUM_R)):
  - Pushes the read channel ID at grant time; it is ordered consistently with cmd_reg.
  - Pops on sram_data_out_valid.
  - On a pop, r_dout_valid[head]=1 and r_dout=sram_data_out, combinationally in the same cycle.
- Simultaneous push and pop: occupancy is unchanged, and a full FIFO permits the push.
- outstanding = tag FIFO occupancy.
- Underflow: sram_data_out_valid with an empty FIFO sets tag_underflow (sticky until reset). Data is dropped, r_dout_valid stays all-zero, and pointers do not move.
- Reset, applied synchronously on the next edge including mid-operation:
  - cmd_reg and tag FIFO are emptied; last_grant = N-1, so index 0 wins first.
  - outstanding=0, tag_underflow=0, and all ready outputs and sram_addr_valid read 0.
  - Reads in flight at reset are discarded; their later returns flag underflow.
- No starvation: every continuously eligible requester is granted within N grants.

Decomposition:
- Package sram_arb_pkg: a localparam for N, a clog2 helper function, and the command-field offset constants.
- Sub-module sram_tag_fifo: synchronous FIFO with push/pop/full/empty/count outputs.
- Round-robin grant logic stays inline.

Test Plan:
- Defaults; w_valid=2'b11, r_valid=2'b11 held, sram_ready=1 → grant order W0,W1,R0,R1,W0…; sram_addr_valid continuous with no bubbles.
- Only R1 valid, addr 18'h00ABC, SRAM returns 32'hDEADBEEF 3 cycles later → r_dout_valid=2'b10 for 1 cycle with r_dout=32'hDEADBEEF; outstanding goes 0→1→0.
- 8 reads issued with no returns → outstanding=8, no further r_ready, writes still granted; one return → one further read grant.
- r_dout_full[0]=1 with R0 and R1 valid → only R1 granted; deassert → R0 granted next.
- sram_ready=0 for 5 cycles during W0 (addr 18'h3FFFF, mask 4'b0101) → command held stable, no new readies; ready=1 → accepted once.
- sram_data_out_valid with outstanding=0 → tag_underflow=1, no r_dout_valid; reset mid-burst → all outputs 0 next cycle, tag_underflow cleared.

Source files
------------

// File: rtl/sram_rr_arbiter_pkg.sv
// sram_arb_pkg: shared defaults, command-register field layout and a width helper.
package sram_arb_pkg;
  localparam int NUM_W_DEF = 2;
  localparam int NUM_R_DEF = 2;
  localparam int CMD_VLD = 0;
  localparam int CMD_RD = 1;
  localparam int CMD_ADDR = 2;
  function automatic int clog2_min1(input int v);
    return v <= 2 ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/sram_rr_arbiter_if.sv
// sram_rr_arbiter_if: request channels, read-return steering and SRAM command port of the arbiter.
interface sram_rr_arbiter_if #(
  parameter int NUM_W     = 2,
  parameter int NUM_R     = 2,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int TAG_DEPTH = 8
);
  logic [NUM_W-1:0]                 w_valid;
  logic [NUM_W-1:0]                 w_ready;
  logic [NUM_W*ADDR_W-1:0]          w_addr;
  logic [NUM_W*DATA_W-1:0]          w_data;
  logic [NUM_W*MASK_W-1:0]          w_mask;
  logic [NUM_R-1:0]                 r_valid;
  logic [NUM_R-1:0]                 r_ready;
  logic [NUM_R*ADDR_W-1:0]          r_addr;
  logic [NUM_R-1:0]                 r_dout_full;
  logic [NUM_R-1:0]                 r_dout_valid;
  logic [DATA_W-1:0]                r_dout;
  logic                             sram_addr_valid;
  logic                             sram_ready;
  logic [ADDR_W-1:0]                sram_addr;
  logic [DATA_W-1:0]                sram_data_in;
  logic [MASK_W-1:0]                sram_write_mask;
  logic [DATA_W-1:0]                sram_data_out;
  logic                             sram_data_out_valid;
  logic [$clog2(TAG_DEPTH+1)-1:0]   outstanding;
  logic                             tag_underflow;
  modport master (
    output w_valid, w_addr, w_data, w_mask, r_valid, r_addr, r_dout_full,
           sram_ready, sram_data_out, sram_data_out_valid,
    input  w_ready, r_ready, r_dout_valid, r_dout, sram_addr_valid, sram_addr,
           sram_data_in, sram_write_mask, outstanding, tag_underflow
  );
  modport slave (
    input  w_valid, w_addr, w_data, w_mask, r_valid, r_addr, r_dout_full,
           sram_ready, sram_data_out, sram_data_out_valid,
    output w_ready, r_ready, r_dout_valid, r_dout, sram_addr_valid, sram_addr,
           sram_data_in, sram_write_mask, outstanding, tag_underflow
  );
endinterface

// File: rtl/sram_tag_fifo.sv
// sram_tag_fifo: power-of-two-depth FIFO; a push into a full FIFO is accepted when a pop coincides.
module sram_tag_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  always_comb begin
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + PW'(do_push);
    rd_d = rd_q + PW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: round-robin arbitration of write/read channels onto one registered SRAM
// command port; read returns are steered by a FIFO of issued read channel IDs.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_W     = NUM_W_DEF,
  parameter int NUM_R     = NUM_R_DEF,
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int TAG_DEPTH = 8
) (
  input logic sram_clock,
  input logic reset,
  sram_rr_arbiter_if.slave bus
);
  localparam int N = NUM_W + NUM_R;
  localparam int GW = clog2_min1(N);
  localparam int TW = clog2_min1(NUM_R);
  localparam int CW = $clog2(TAG_DEPTH + 1);
  localparam int CMD_DATA = CMD_ADDR + ADDR_W;
  localparam int CMD_MASK = CMD_DATA + DATA_W;
  localparam int CMD_W = CMD_MASK + MASK_W;
  logic [CMD_W-1:0] cmd_q, cmd_d, ld;
  logic [GW-1:0] last_q, last_d, gnt_idx;
  logic uf_q, uf_d;
  logic [N-1:0] elig;
  logic can_load, grant, push, pop, full, empty;
  logic [TW-1:0] push_id, head;
  logic [CW-1:0] count;
  sram_tag_fifo #(.W(TW), .DEPTH(TAG_DEPTH)) u_tags (
    .clk(sram_clock), .rst(reset), .push(push), .pop(pop), .din(push_id),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  always_comb begin : arb
    int d;
    int best;
    elig = {bus.r_valid & ~bus.r_dout_full & {NUM_R{~full}}, bus.w_valid};
    can_load = ~cmd_q[CMD_VLD] | bus.sram_ready;
    // Winner is the eligible index at the smallest circular distance past last_q.
    best = N + 1;
    gnt_idx = last_q;
    for (int i = 0; i < N; i++) begin
      d = i - int'(last_q);
      d = d <= 0 ? d + N : d;
      if (elig[i] && d < best) begin
        best = d;
        gnt_idx = GW'(i);
      end
    end
    grant = best <= N && can_load && !reset;
    push = grant && int'(gnt_idx) >= NUM_W;
    push_id = TW'(int'(gnt_idx) - NUM_W);
    pop = bus.sram_data_out_valid & ~empty;
    bus.r_dout_valid = pop ? NUM_R'(1) << head : '0;
    ld = '0;
    ld[CMD_VLD] = 1'b1;
    for (int i = 0; i < NUM_W; i++) begin
      bus.w_ready[i] = grant && int'(gnt_idx) == i;
      if (int'(gnt_idx) == i) begin
        ld[CMD_ADDR +: ADDR_W] = bus.w_addr[i*ADDR_W +: ADDR_W];
        ld[CMD_DATA +: DATA_W] = bus.w_data[i*DATA_W +: DATA_W];
        ld[CMD_MASK +: MASK_W] = bus.w_mask[i*MASK_W +: MASK_W];
      end
    end
    for (int j = 0; j < NUM_R; j++) begin
      bus.r_ready[j] = grant && int'(gnt_idx) == NUM_W + j;
      if (int'(gnt_idx) == NUM_W + j) begin
        ld[CMD_RD] = 1'b1;
        ld[CMD_ADDR +: ADDR_W] = bus.r_addr[j*ADDR_W +: ADDR_W];
      end
    end
    cmd_d = grant ? ld : (bus.sram_ready ? '0 : cmd_q);
    last_d = grant ? gnt_idx : last_q;
    uf_d = uf_q | (bus.sram_data_out_valid & empty);
  end
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      cmd_q <= '0;
      last_q <= GW'(N - 1);
      uf_q <= 1'b0;
    end else begin
      cmd_q <= cmd_d;
      last_q <= last_d;
      uf_q <= uf_d;
    end
  end
  assign bus.sram_addr_valid = cmd_q[CMD_VLD];
  assign bus.sram_addr = cmd_q[CMD_ADDR +: ADDR_W];
  assign bus.sram_data_in = cmd_q[CMD_RD] ? '0 : cmd_q[CMD_DATA +: DATA_W];
  assign bus.sram_write_mask = cmd_q[CMD_MASK +: MASK_W];
  assign bus.r_dout = bus.sram_data_out;
  assign bus.outstanding = count;
  assign bus.tag_underflow = uf_q;
endmodule
